dma_engine: RTL and testbench
=============================

DMA_ENGINE -- requirements
Module: dma_engine

Interface
REQ-001 Parameter XLEN, default 32, data/address width.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 dma_en_i  input  1  one-cycle command strobe from core EX stage.
REQ-005 dma_funct3_i  input  3  operation: 000 COPY, 001 FILL, other values ignored.
REQ-006 dma_imm_i  input  12  length in words, unsigned; 0 means no-op.
REQ-007 dma_rs1_i  input  XLEN  COPY: source address; FILL: fill value.
REQ-008 dma_rs2_i  input  XLEN  destination address.
REQ-009 dma_busy_o  output  1  engine owns data memory; core stalls while high.
REQ-010 mem_req_o  output  1  data-memory request.
REQ-011 mem_gnt_i  input  1  grant; transfer occurs in a cycle with mem_req_o=1 and mem_gnt_i=1.
REQ-012 mem_addr_o  output  XLEN  word address, bits [1:0] always 0.
REQ-013 mem_wr_data_o  output  XLEN  write data.
REQ-014 mem_size_o  output  4  byte enables, always 4'b1111 while mem_req_o=1, else 0.
REQ-015 mem_read_o / mem_write_o  output  1 each  access type, mutually exclusive, only with mem_req_o.
REQ-016 mem_rd_data_i  input  XLEN  read data, valid the cycle after a granted read.

Function
REQ-017 States: IDLE, RD_REQ, RD_DATA, WR_REQ.
REQ-018 IDLE: dma_en_i=1 with funct3 000/001 and imm!=0 latches src=rs1&~3, dst=rs2&~3, fill value=rs1, count=imm, op; next state RD_REQ (COPY) or WR_REQ (FILL).
REQ-019 IDLE: dma_en_i with imm=0 or unsupported funct3 is dropped; state stays IDLE, busy stays 0.
REQ-020 dma_en_i outside IDLE is ignored; latched command unaffected.
REQ-021 dma_busy_o = (state != IDLE), registered; rises the cycle after an accepted dma_en_i.
REQ-022 RD_REQ: mem_req_o=1, mem_read_o=1, mem_addr_o=src; held stable until grant; on grant -> RD_DATA, src += 4.
REQ-023 RD_DATA: mem_req_o=0; capture mem_rd_data_i into data buffer; -> WR_REQ.
REQ-024 WR_REQ: mem_req_o=1, mem_write_o=1, mem_addr_o=dst, mem_wr_data_o=buffer (COPY) or fill value (FILL); held stable until grant.
REQ-025 On WR_REQ grant: dst += 4, count -= 1; count reaching 0 -> IDLE, else -> RD_REQ (COPY) or stay WR_REQ (FILL).
REQ-026 Address increments wrap modulo 2^XLEN; no error signalled.
REQ-027 Throughput with mem_gnt_i tied high: COPY 3 cycles/word, FILL 1 cycle/word; each cycle of gnt low adds one cycle.
REQ-028 Total busy cycles for N words, gnt always high: COPY 3N, FILL N.
REQ-029 Outputs with mem_req_o=0: mem_addr_o, mem_wr_data_o, mem_size_o, mem_read_o, mem_write_o all 0.
REQ-030 No request is withdrawn before grant; dma_busy_o never drops while mem_req_o=1.

Reset
REQ-031 rst_i=1 at a clock edge: state IDLE, count 0, address/data registers 0; all outputs 0 from the following cycle.
REQ-032 Reset mid-transfer abandons the command; no further memory access; pending grant ignored.
REQ-033 Reset takes priority over a simultaneous dma_en_i.

Verification
REQ-034 COPY rs1=0x1000_0000, rs2=0x1000_0100, imm=4, gnt high, memory preloaded 0xA0..0xA3 -> dst words equal source, busy high exactly 12 cycles.
REQ-035 FILL rs1=0xDEAD_BEEF, rs2=0x2000_0003, imm=3 -> writes at 0x2000_0000/04/08, busy 3 cycles.
REQ-036 COPY imm=2 with gnt low 2 cycles on each request -> address/data stable while waiting, busy 14 cycles, data correct.
REQ-037 dma_en_i with imm=0, then funct3=010 imm=5 -> busy stays 0, no mem_req_o.
REQ-038 FILL imm=100, rst_i asserted at cycle 10 -> mem_req_o 0 and busy 0 the next cycle, no writes after reset.
REQ-039 COPY rs2=0xFFFF_FFF8, imm=3 -> writes to 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/dma_engine.sv
// dma_engine: single-channel word DMA executing COPY/FILL commands strobed from the core.
// Owns the data-memory port while busy; all outputs are registered from next-state values.
module dma_engine #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            dma_en_i,
  input  logic [2:0]      dma_funct3_i,
  input  logic [11:0]     dma_imm_i,
  input  logic [XLEN-1:0] dma_rs1_i,
  input  logic [XLEN-1:0] dma_rs2_i,
  output logic            dma_busy_o,
  output logic            mem_req_o,
  input  logic            mem_gnt_i,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wr_data_o,
  output logic [3:0]      mem_size_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  input  logic [XLEN-1:0] mem_rd_data_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_DATA = 2'd2,
    WR_REQ  = 2'd3
  } state_e;

  localparam logic [2:0]      FUNCT3_COPY = 3'b000;
  localparam logic [2:0]      FUNCT3_FILL = 3'b001;
  localparam logic [XLEN-1:0] WORD_MASK   = ~XLEN'(3);
  localparam logic [XLEN-1:0] ADDR_STEP   = XLEN'(4);

  state_e            state_q, state_d;
  logic              op_fill_q, op_fill_d;
  logic [XLEN-1:0]   src_q, src_d;
  logic [XLEN-1:0]   dst_q, dst_d;
  logic [XLEN-1:0]   fill_q, fill_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [11:0]       count_q, count_d;

  logic              busy_q, busy_d;
  logic              req_q, req_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wr_data_q, wr_data_d;
  logic [3:0]        size_q, size_d;

  logic              cmd_ok;

  assign cmd_ok = dma_en_i
               && ((dma_funct3_i == FUNCT3_COPY) || (dma_funct3_i == FUNCT3_FILL))
               && (dma_imm_i != 12'd0);

  always_comb begin
    state_d   = state_q;
    op_fill_d = op_fill_q;
    src_d     = src_q;
    dst_d     = dst_q;
    fill_d    = fill_q;
    data_d    = data_q;
    count_d   = count_q;

    case (state_q)
      IDLE: begin
        if (cmd_ok) begin
          op_fill_d = (dma_funct3_i == FUNCT3_FILL);
          src_d     = dma_rs1_i & WORD_MASK;
          dst_d     = dma_rs2_i & WORD_MASK;
          fill_d    = dma_rs1_i;
          count_d   = dma_imm_i;
          state_d   = (dma_funct3_i == FUNCT3_FILL) ? WR_REQ : RD_REQ;
        end
      end
      RD_REQ: begin
        if (mem_gnt_i) begin
          src_d   = src_q + ADDR_STEP;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        data_d  = mem_rd_data_i;
        state_d = WR_REQ;
      end
      WR_REQ: begin
        if (mem_gnt_i) begin
          dst_d   = dst_q + ADDR_STEP;
          count_d = count_q - 12'd1;
          if (count_q == 12'd1) begin
            state_d = IDLE;
          end else if (!op_fill_q) begin
            state_d = RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Port outputs are derived from the next state so they appear in the same cycle as the state.
    busy_d    = (state_d != IDLE);
    req_d     = (state_d == RD_REQ) || (state_d == WR_REQ);
    read_d    = (state_d == RD_REQ);
    write_d   = (state_d == WR_REQ);
    size_d    = req_d ? 4'b1111 : 4'b0000;
    addr_d    = '0;
    wr_data_d = '0;
    if (state_d == RD_REQ) begin
      addr_d = src_d;
    end else if (state_d == WR_REQ) begin
      addr_d    = dst_d;
      wr_data_d = op_fill_d ? fill_d : data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_fill_q <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      fill_q    <= '0;
      data_q    <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      req_q     <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      size_q    <= '0;
    end else begin
      state_q   <= state_d;
      op_fill_q <= op_fill_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      fill_q    <= fill_d;
      data_q    <= data_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      req_q     <= req_d;
      read_q    <= read_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      size_q    <= size_d;
    end
  end

  assign dma_busy_o    = busy_q;
  assign mem_req_o     = req_q;
  assign mem_read_o    = read_q;
  assign mem_write_o   = write_q;
  assign mem_addr_o    = addr_q;
  assign mem_wr_data_o = wr_data_q;
  assign mem_size_o    = size_q;

endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: drives COPY/FILL commands against a word memory model with configurable grant
// behaviour and compares every write, busy length and port behaviour with a reference model.
module tb_dma_engine;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        dma_en_i = 1'b0;
  logic [2:0]  dma_funct3_i = 3'b000;
  logic [11:0] dma_imm_i = 12'd0;
  logic [31:0] dma_rs1_i = 32'd0;
  logic [31:0] dma_rs2_i = 32'd0;
  logic        dma_busy_o;
  logic        mem_req_o;
  logic        mem_gnt_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wr_data_o;
  logic [3:0]  mem_size_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_rd_data_i = 32'd0;

  dma_engine #(.XLEN(32)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .dma_en_i      (dma_en_i),
    .dma_funct3_i  (dma_funct3_i),
    .dma_imm_i     (dma_imm_i),
    .dma_rs1_i     (dma_rs1_i),
    .dma_rs2_i     (dma_rs2_i),
    .dma_busy_o    (dma_busy_o),
    .mem_req_o     (mem_req_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_addr_o    (mem_addr_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_size_o    (mem_size_o),
    .mem_read_o    (mem_read_o),
    .mem_write_o   (mem_write_o),
    .mem_rd_data_i (mem_rd_data_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          mode;
    int          exp_busy;
    int          exp_writes;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  // Two copies of memory: one the DUT actually reads/writes, one updated only by the model.
  logic [31:0] mem_dut [logic [31:0]];
  logic [31:0] mem_ref [logic [31:0]];
  wr_t         wlog[$];

  int gnt_mode = 0;
  bit mon_en = 1'b0;
  int busy_cycles = 0, req_cycles = 0, stall_cycles = 0, viol_cnt = 0;
  int busy0, req0, stall0, viol0, w0;
  int errors = 0, checks = 0;

  function automatic logic [31:0] memDefault(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    if (mem_ref.exists(a)) return mem_ref[a];
    return memDefault(a);
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    mem_dut[a] = d;
    mem_ref[a] = d;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Memory/arbiter model: grants at the negedge, returns read data one cycle after a grant,
  // and watches the request port for stability and idle-zero behaviour.
  logic        rd_pending = 1'b0;
  logic [31:0] rd_val = 32'd0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'd0, prev_data = 32'd0;
  logic        prev_rd = 1'b0, prev_wr = 1'b0;
  int          wait_cnt = 0;

  always @(negedge clk_i) begin
    mem_rd_data_i = rd_pending ? rd_val : $urandom();
    rd_pending = 1'b0;
    if (mon_en) begin
      if (mem_req_o) begin
        if (mem_size_o != 4'hF || mem_addr_o[1:0] != 2'b00 || mem_read_o == mem_write_o || !dma_busy_o) begin
          viol_cnt++;
          $display("[TB] protocol: bad active request at %0t", $time);
        end
      end else if (mem_addr_o != 0 || mem_wr_data_o != 0 || mem_size_o != 0 || mem_read_o || mem_write_o) begin
        viol_cnt++;
        $display("[TB] protocol: nonzero idle outputs at %0t", $time);
      end
      if (prev_wait && (!mem_req_o || mem_addr_o != prev_addr || mem_wr_data_o != prev_data
                        || mem_read_o != prev_rd || mem_write_o != prev_wr)) begin
        viol_cnt++;
        $display("[TB] protocol: request changed before grant at %0t", $time);
      end
      if (dma_busy_o) busy_cycles++;
      if (mem_req_o) req_cycles++;
    end
    if (mem_gnt_i || !mem_req_o) wait_cnt = 0;
    if (gnt_mode == 2) begin
      mem_gnt_i = ($urandom_range(0, 3) != 0);
    end else if (gnt_mode == 1 && mem_req_o && wait_cnt < 2) begin
      mem_gnt_i = 1'b0;
      wait_cnt++;
    end else begin
      mem_gnt_i = 1'b1;
    end
    if (mon_en && mem_req_o && !mem_gnt_i) stall_cycles++;
    if (mon_en && mem_req_o && mem_gnt_i && !rst_i) begin
      if (mem_write_o) begin
        wlog.push_back('{addr: mem_addr_o, data: mem_wr_data_o});
        mem_dut[mem_addr_o] = mem_wr_data_o;
      end else if (mem_read_o) begin
        rd_pending = 1'b1;
        rd_val = mem_dut.exists(mem_addr_o) ? mem_dut[mem_addr_o] : memDefault(mem_addr_o);
      end
    end
    prev_wait = mon_en && mem_req_o && !mem_gnt_i && !rst_i;
    prev_addr = mem_addr_o;
    prev_data = mem_wr_data_o;
    prev_rd   = mem_read_o;
    prev_wr   = mem_write_o;
  end

  task automatic applyStimulus(input logic [2:0] f3, input logic [11:0] imm, input logic [31:0] rs1,
                               input logic [31:0] rs2, input int mode, input bit interfere);
    int n;
    @(posedge clk_i); #1;
    gnt_mode = mode;
    busy0 = busy_cycles; req0 = req_cycles; stall0 = stall_cycles; viol0 = viol_cnt; w0 = wlog.size();
    dma_en_i = 1'b1; dma_funct3_i = f3; dma_imm_i = imm; dma_rs1_i = rs1; dma_rs2_i = rs2;
    @(posedge clk_i); #1;
    dma_en_i = 1'b0;
    if (interfere) begin
      dma_en_i = 1'b1; dma_funct3_i = 3'b001; dma_imm_i = 12'd7;
      dma_rs1_i = 32'h5555_AAAA; dma_rs2_i = 32'h0000_8000;
      @(posedge clk_i); #1;
      dma_en_i = 1'b0;
    end
    n = 0;
    while (dma_busy_o && n < 5000) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (dma_busy_o) begin
      checkOutput("busy_timeout", 64'd1, 64'd0);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
    end
    @(negedge clk_i);
    @(posedge clk_i); #1;
  endtask

  // Reference: a command moves imm words in address order; each word costs 3 cycles (COPY)
  // or 1 (FILL) plus one cycle per refused request cycle.
  task automatic checkAgainstModel(input logic [2:0] f3, input logic [11:0] imm,
                                   input logic [31:0] rs1, input logic [31:0] rs2);
    bit          accepted;
    int          words, got_w, stalls;
    logic [31:0] a, d;
    accepted = (imm != 12'd0) && (f3 == 3'b000 || f3 == 3'b001);
    words    = accepted ? int'(imm) : 0;
    got_w    = wlog.size() - w0;
    stalls   = stall_cycles - stall0;
    checkOutput("write_count", got_w, words);
    checkOutput("busy_cycles", busy_cycles - busy0, accepted ? ((f3 == 3'b000) ? 3 : 1) * words + stalls : 0);
    checkOutput("req_cycles", req_cycles - req0, accepted ? ((f3 == 3'b000) ? 2 : 1) * words + stalls : 0);
    checkOutput("protocol", viol_cnt - viol0, 0);
    for (int i = 0; i < words; i++) begin
      a = (rs2 & 32'hFFFF_FFFC) + 32'(4 * i);
      d = (f3 == 3'b001) ? rs1 : refRead((rs1 & 32'hFFFF_FFFC) + 32'(4 * i));
      mem_ref[a] = d;
      if (i < got_w) begin
        checkOutput("write_addr", wlog[w0 + i].addr, a);
        checkOutput("write_data", wlog[w0 + i].data, d);
      end
    end
  endtask

  initial begin
    vec_t        vecs[7];
    logic [2:0]  f3tab[6];
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [31:0] rs1, rs2;
    int          nw, mark;

    vecs[0] = '{3'b000, 12'd4, 32'h1000_0000, 32'h1000_0100, 0, 12, 4, 32'h1000_0100, 32'h1000_010C};
    vecs[1] = '{3'b001, 12'd3, 32'hDEAD_BEEF, 32'h2000_0003, 0, 3, 3, 32'h2000_0000, 32'h2000_0008};
    vecs[2] = '{3'b000, 12'd2, 32'h1000_0000, 32'h1000_0200, 1, 14, 2, 32'h1000_0200, 32'h1000_0204};
    vecs[3] = '{3'b000, 12'd0, 32'h1000_0000, 32'h1000_0300, 0, 0, 0, 32'h0, 32'h0};
    vecs[4] = '{3'b010, 12'd5, 32'h1000_0000, 32'h1000_0300, 0, 0, 0, 32'h0, 32'h0};
    vecs[5] = '{3'b000, 12'd3, 32'h1000_0000, 32'hFFFF_FFF8, 0, 9, 3, 32'hFFFF_FFF8, 32'h0000_0000};
    vecs[6] = '{3'b001, 12'd1, 32'h0000_0007, 32'h0000_0040, 0, 1, 1, 32'h0000_0040, 32'h0000_0040};
    f3tab = '{3'b000, 3'b001, 3'b000, 3'b001, 3'b010, 3'b111};

    for (int i = 0; i < 4; i++) poke(32'h1000_0000 + 32'(4 * i), 32'hA0 + 32'(i));

    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    checkOutput("reset_busy", dma_busy_o, 0);
    checkOutput("reset_req", mem_req_o, 0);
    checkOutput("reset_addr", mem_addr_o, 0);
    checkOutput("reset_wdata", mem_wr_data_o, 0);
    checkOutput("reset_size", mem_size_o, 0);
    checkOutput("reset_read", mem_read_o, 0);
    checkOutput("reset_write", mem_write_o, 0);
    mon_en = 1'b1;

    $display("[TB] directed vector table");
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].f3, vecs[v].imm, vecs[v].rs1, vecs[v].rs2, vecs[v].mode, 1'b0);
      nw = wlog.size() - w0;
      checkOutput("table_busy", busy_cycles - busy0, vecs[v].exp_busy);
      checkOutput("table_writes", nw, vecs[v].exp_writes);
      if (nw > 0) begin
        checkOutput("table_first_addr", wlog[w0].addr, vecs[v].exp_first);
        checkOutput("table_last_addr", wlog[w0 + nw - 1].addr, vecs[v].exp_last);
      end
      checkAgainstModel(vecs[v].f3, vecs[v].imm, vecs[v].rs1, vecs[v].rs2);
    end

    $display("[TB] command strobe while busy");
    applyStimulus(3'b000, 12'd2, 32'h1000_0000, 32'h1000_0400, 0, 1'b1);
    checkAgainstModel(3'b000, 12'd2, 32'h1000_0000, 32'h1000_0400);

    $display("[TB] reset in the middle of a long fill");
    gnt_mode = 0;
    w0 = wlog.size();
    @(posedge clk_i); #1;
    dma_en_i = 1'b1; dma_funct3_i = 3'b001; dma_imm_i = 12'd100;
    dma_rs1_i = 32'h1234_5678; dma_rs2_i = 32'h3000_0000;
    @(posedge clk_i); #1;
    dma_en_i = 1'b0;
    repeat (10) begin
      @(posedge clk_i); #1;
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    checkOutput("rst_mid_busy", dma_busy_o, 0);
    checkOutput("rst_mid_req", mem_req_o, 0);
    nw = wlog.size() - w0;
    checkOutput("rst_mid_writes", nw, 10);
    if (nw > 0) begin
      checkOutput("rst_mid_last_addr", wlog[w0 + nw - 1].addr, 32'h3000_0000 + 32'(4 * (nw - 1)));
      checkOutput("rst_mid_last_data", wlog[w0 + nw - 1].data, 32'h1234_5678);
    end
    for (int i = 0; i < nw; i++) mem_ref[wlog[w0 + i].addr] = wlog[w0 + i].data;
    mark = req_cycles;
    repeat (20) begin
      @(posedge clk_i); #1;
    end
    checkOutput("rst_mid_req_after", req_cycles - mark, 0);
    checkOutput("rst_mid_writes_after", wlog.size() - w0, nw);

    $display("[TB] reset together with a command strobe");
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    dma_en_i = 1'b1; dma_funct3_i = 3'b001; dma_imm_i = 12'd5;
    dma_rs1_i = 32'h0BAD_F00D; dma_rs2_i = 32'h0000_1000;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    dma_en_i = 1'b0;
    checkOutput("rst_prio_busy", dma_busy_o, 0);
    mark = req_cycles;
    repeat (5) begin
      @(posedge clk_i); #1;
    end
    checkOutput("rst_prio_req", req_cycles - mark, 0);

    $display("[TB] randomized commands");
    for (int t = 0; t < 12; t++) begin
      f3  = f3tab[$urandom_range(0, 5)];
      imm = 12'($urandom_range(0, 9));
      rs1 = $urandom();
      rs2 = (t % 3 == 0) ? rs1 + 32'($urandom_range(0, 16)) : $urandom();
      applyStimulus(f3, imm, rs1, rs2, int'($urandom_range(0, 2)), 1'b0);
      checkAgainstModel(f3, imm, rs1, rs2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
